button_event_scheduler: RTL and testbench
=========================================

// Module: button_event_scheduler
// PURPOSE
//  Turns N debounced button levels (debouncer outputs) into one serialized stream of
//  press events with hold-to-repeat. Arbitrates round-robin between buttons into a
//  single valid/ready channel consumed by the etch-a-sketch cursor/draw controller.
//  Sole sequencer between the debounced inputs and the drawing datapath.
// PARAMETERS
//  N_BUTTONS      4    number of debounced inputs, >=2
//  REPEAT_DELAY   50   cycles of continuous hold after press before first repeat, >=2
//  REPEAT_PERIOD  10   cycles between subsequent repeats, >=2
// PORTS
//  clk            in   1                  clock, all logic on posedge
//  rst            in   1                  asynchronous, active-low reset
//  buttons        in   N_BUTTONS          debounced levels, 1 = pressed
//  event_ready    in   1                  consumer accepts event this cycle
//  event_valid    out  1                  event_id/event_repeat hold an event
//  event_id       out  $clog2(N_BUTTONS)  index of the button for this event
//  event_repeat   out  1                  0 = initial press, 1 = auto-repeat
//  clr_overflow   in   1                  clears overflow
//  overflow       out  1                  sticky: an event was dropped
// BEHAVIOUR
//  Reset (rst=0, async): event_valid=0, event_id=0, event_repeat=0, overflow=0,
//   all pending=0, all per-button FSMs IDLE, counters 0, buttons_prev=0, rr_ptr=0.
//  Per-button FSM (i): IDLE -> DELAY on buttons[i]&~buttons_prev[i] (raise press event,
//   counter=0). DELAY: counter++; at counter==REPEAT_DELAY-1 raise repeat event,
//   counter=0, -> REPEAT. REPEAT: counter++; at REPEAT_PERIOD-1 raise repeat event,
//   counter=0. Any state with buttons[i]=0 -> IDLE, counter=0, no event that cycle.
//  Event raised -> pending[i]<=1, pend_rep[i]<=repeat flag, registered next edge.
//  Pending already set and not granted this cycle -> new event dropped, stored
//   flag unchanged, overflow<=1. Granted same cycle as new event -> pending stays 1
//   with new flag, no overflow.
//  Output slot free when ~event_valid | event_ready. If free and any pending: pick
//   first pending at or after rr_ptr (wrap mod N_BUTTONS), load event_id/event_repeat,
//   event_valid<=1, clear that pending bit, rr_ptr<=winner+1 mod N. If free and
//   none pending: event_valid<=0.
//  event_valid/id/repeat are registered and hold stable while valid & ~ready.
//  Latency: rising edge on buttons[i] sampled at cycle t -> pending at t+1 ->
//   event_valid at t+2 (idle output, no contention). Back-to-back events 1/cycle
//   under continuous ready.
//  Release never cancels an already-pending or presented event.
//  overflow: set as above; clr_overflow clears it; simultaneous set and clear -> 1.
//  Counters sized $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)); never wrap past limit.
// TESTING
//  1 Reset: hold rst=0 with buttons=4'b1111 -> all outputs 0; release rst with
//    buttons still 4'b1111 -> presses seen from buttons_prev=0: events id 0,1,2,3.
//  2 Single press: buttons[2] 0->1 at t, ready=1 -> valid at t+2, id=2, repeat=0,
//    valid for exactly 1 cycle.
//  3 Simultaneous: buttons 0000->1010, ready=1 -> id=1 then id=3 on consecutive
//    cycles; next press of 1 and 3 together with rr_ptr=0 -> id=1 then id=3.
//  4 Repeat (DELAY=5, PERIOD=3): hold buttons[0] 20 cycles -> press event, repeat
//    event 5 cycles later, then every 3 cycles; release -> no further events.
//  5 Backpressure: ready=0, press 0 and 1 -> id0 held stable, pending[1]=1; press 1
//    again -> overflow=1; ready=1 -> id0, id1 delivered; clr_overflow -> overflow=0.
//  6 Async reset mid-hold in REPEAT with valid=1 -> outputs 0 immediately, no event
//    until a fresh 0->1 edge after rst=1.

Source files
------------

// File: rtl/button_event_scheduler.sv
// button_event_scheduler
//   Converts N debounced button levels into a serialized stream of press and
//   hold-to-repeat events. Each button runs a small IDLE/DELAY/REPEAT FSM that
//   raises events into a one-deep pending slot. A round-robin arbiter moves
//   pending events into a registered valid/ready output stage. An event raised
//   while its slot is still occupied is dropped and flagged on sticky overflow.
module button_event_scheduler #(
  parameter int  N_BUTTONS     = 4,
  parameter int  REPEAT_DELAY  = 50,
  parameter int  REPEAT_PERIOD = 10,
  localparam int ID_W          = $clog2(N_BUTTONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] buttons,
  input  logic                 event_ready,
  output logic                 event_valid,
  output logic [ID_W-1:0]      event_id,
  output logic                 event_repeat,
  input  logic                 clr_overflow,
  output logic                 overflow
);

  // The counter only ever counts up to the larger of the two limits minus one.
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } btn_state_t;

  btn_state_t           state_q [N_BUTTONS];
  logic [CNT_W-1:0]     cnt_q   [N_BUTTONS];
  logic [N_BUTTONS-1:0] buttons_prev;

  logic [N_BUTTONS-1:0] raise;       // an event is generated this cycle
  logic [N_BUTTONS-1:0] raise_rep;   // ... and it is an auto-repeat
  logic [N_BUTTONS-1:0] pending_q;
  logic [N_BUTTONS-1:0] pend_rep_q;
  logic [N_BUTTONS-1:0] grant_mask;
  logic [N_BUTTONS-1:0] drop;

  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      grant_id;
  logic                 grant_valid;
  logic                 slot_free;

  // Event decode: a press fires on a rising level seen from IDLE, repeats fire
  // when the hold counter reaches its limit. A released button never fires.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned; a missing default would infer a latch.
    raise     = '0;
    raise_rep = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      if (buttons[i]) begin
        unique case (state_q[i])
          ST_IDLE:   raise[i] = ~buttons_prev[i];
          ST_DELAY:  if (cnt_q[i] == DELAY_LAST) begin
                       raise[i]     = 1'b1;
                       raise_rep[i] = 1'b1;
                     end
          ST_REPEAT: if (cnt_q[i] == PERIOD_LAST) begin
                       raise[i]     = 1'b1;
                       raise_rep[i] = 1'b1;
                     end
          default:   ;
        endcase
      end
    end
  end

  // Per-button hold FSMs and the previous-level register used for edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buttons_prev <= '0;
      // NOTE: the per-button state/counter arrays are a handful of flops, not a
      // RAM, so they are reset like any other register.
      for (int i = 0; i < N_BUTTONS; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      // NOTE: state is updated with non-blocking assignments so every FSM sees
      // the values from the start of the cycle, matching the comb decode above.
      buttons_prev <= buttons;
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (!buttons[i]) begin
          state_q[i] <= ST_IDLE;
          cnt_q[i]   <= '0;
        end else begin
          unique case (state_q[i])
            ST_IDLE: begin
              if (raise[i]) begin
                state_q[i] <= ST_DELAY;
                cnt_q[i]   <= '0;
              end
            end
            ST_DELAY: begin
              if (raise[i]) begin
                state_q[i] <= ST_REPEAT;
                cnt_q[i]   <= '0;
              end else begin
                cnt_q[i] <= cnt_q[i] + 1'b1;
              end
            end
            ST_REPEAT: begin
              if (raise[i]) cnt_q[i] <= '0;
              else          cnt_q[i] <= cnt_q[i] + 1'b1;
            end
            default: begin
              state_q[i] <= ST_IDLE;
              cnt_q[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

  // Round-robin search: first pending button at or after rr_ptr, wrapping.
  always_comb begin
    logic [ID_W-1:0] idx;
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int k = 0; k < N_BUTTONS; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % N_BUTTONS);
      if (!grant_valid && pending_q[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end

  assign slot_free = ~event_valid | event_ready;

  // One-hot of the pending bit being moved into the output stage this cycle.
  always_comb begin
    grant_mask = '0;
    if (slot_free && grant_valid) grant_mask[grant_id] = 1'b1;
  end

  // A new event is lost only when its slot is full and not emptying this cycle.
  assign drop = raise & pending_q & ~grant_mask;

  // Pending slots and the sticky overflow flag; a set beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q  <= '0;
      pend_rep_q <= '0;
      overflow   <= 1'b0;
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (raise[i]) begin
          if (!drop[i]) begin
            pending_q[i]  <= 1'b1;
            pend_rep_q[i] <= raise_rep[i];
          end
        end else if (grant_mask[i]) begin
          pending_q[i] <= 1'b0;
        end
      end
      if (|drop)             overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  // Registered output stage; holds its contents while valid and not ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      event_valid  <= 1'b0;
      event_id     <= '0;
      event_repeat <= 1'b0;
      rr_ptr       <= '0;
    end else if (slot_free) begin
      if (grant_valid) begin
        event_valid  <= 1'b1;
        event_id     <= grant_id;
        event_repeat <= pend_rep_q[grant_id];
        rr_ptr       <= ID_W'((int'(grant_id) + 1) % N_BUTTONS);
      end else begin
        event_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_event_scheduler.sv
// tb_button_event_scheduler
//   Scenario tasks plus a long randomized run, all compared every cycle against
//   a behavioural model that tracks how long each button has been held and
//   derives events from that age, with a pending slot per button and a
//   round-robin pick for the output stage.
module tb_button_event_scheduler;

  localparam int N = 4;
  localparam int D = 5;
  localparam int P = 3;

  logic         clk;
  logic         rst;
  logic [N-1:0] buttons;
  logic         event_ready;
  logic         event_valid;
  logic [1:0]   event_id;
  logic         event_repeat;
  logic         clr_overflow;
  logic         overflow;

  int tests;
  int fails;

  button_event_scheduler #(
    .N_BUTTONS     (N),
    .REPEAT_DELAY  (D),
    .REPEAT_PERIOD (P)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .buttons      (buttons),
    .event_ready  (event_ready),
    .event_valid  (event_valid),
    .event_id     (event_id),
    .event_repeat (event_repeat),
    .clr_overflow (clr_overflow),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] dut_vec;
  assign dut_vec = {event_valid, event_id, event_repeat, overflow};

  // ---------------- reference model ----------------
  bit         m_prev [N];
  bit         m_held [N];
  int         m_age  [N];
  bit         m_pend [N];
  bit         m_prep [N];
  bit         m_valid;
  logic [1:0] m_id;
  bit         m_rep;
  bit         m_ovf;
  int         m_rr;

  function automatic logic [4:0] model_vec();
    return {m_valid, m_id, m_rep, m_ovf};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_prev[i] = 0; m_held[i] = 0; m_age[i] = 0; m_pend[i] = 0; m_prep[i] = 0;
    end
    m_valid = 0; m_id = 2'd0; m_rep = 0; m_ovf = 0; m_rr = 0;
  endtask

  // One clock edge: events come from hold age (0 = press, D, D+P, D+2P ... = repeat).
  task automatic model_update();
    bit ev  [N];
    bit evr [N];
    bit slot_free;
    bit lost;
    int win;
    int j;
    for (int i = 0; i < N; i++) begin
      ev[i] = 0; evr[i] = 0;
      if (!buttons[i]) begin
        m_held[i] = 0;
      end else if (!m_prev[i]) begin
        ev[i] = 1; m_held[i] = 1; m_age[i] = 0;
      end else if (m_held[i]) begin
        m_age[i]++;
        if (m_age[i] >= D && (m_age[i] - D) % P == 0) begin
          ev[i] = 1; evr[i] = 1;
        end
      end
      m_prev[i] = buttons[i];
    end
    slot_free = !m_valid || event_ready;
    win = -1;
    if (slot_free) begin
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (win < 0 && m_pend[j]) win = j;
      end
      if (win >= 0) begin
        m_valid = 1; m_id = 2'(win); m_rep = m_prep[win]; m_rr = (win + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
    lost = 0;
    for (int i = 0; i < N; i++) begin
      if (ev[i]) begin
        if (m_pend[i] && win != i) lost = 1;
        else begin m_pend[i] = 1; m_prep[i] = evr[i]; end
      end else if (win == i) begin
        m_pend[i] = 0;
      end
    end
    if (lost) m_ovf = 1;
    else if (clr_overflow) m_ovf = 0;
  endtask

  // Advance one cycle; inputs are changed only at the falling edge by callers.
  task automatic tick();
    @(posedge clk);
    if (rst) model_update();
    else     model_reset();
    @(negedge clk);
  endtask

  task automatic do_reset();
    buttons = '0; event_ready = 1'b1; clr_overflow = 1'b0;
    rst = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int ids[$];
    buttons = 4'b1111; event_ready = 1'b1; clr_overflow = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (3) tick();
    tests++;
    if (dut_vec !== 5'b0) begin
      fails++; $display("FAIL reset_outputs: got %b expected %b", dut_vec, 5'b0);
    end
    rst = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++; $display("FAIL reset_model t=%0d: got %b expected %b", t, dut_vec, model_vec());
      end
      if (event_valid && event_ready && !event_repeat) ids.push_back(int'(event_id));
    end
    tests++;
    if (ids.size() != 4) begin
      fails++; $display("FAIL reset_press_count: got %0d expected 4", ids.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (ids[k] != k) begin
          fails++; $display("FAIL reset_press_order[%0d]: got %0d expected %0d", k, ids[k], k);
        end
      end
    end
    buttons = '0;
    tick();
  endtask

  task automatic test_single_press();
    logic [4:0] exp_seq [3];
    exp_seq = '{5'b0_00_0_0, 5'b1_10_0_0, 5'b0_10_0_0};
    do_reset();
    buttons = 4'b0100;
    for (int t = 0; t < 3; t++) begin
      tick();
      tests++;
      if (dut_vec !== exp_seq[t]) begin
        fails++; $display("FAIL single_press t=%0d: got %b expected %b", t, dut_vec, exp_seq[t]);
      end
    end
    buttons = '0;
    tick();
  endtask

  task automatic test_simultaneous();
    logic [4:0] exp_seq [4];
    do_reset();
    for (int round = 0; round < 2; round++) begin
      exp_seq = '{(round == 0) ? 5'b0_00_0_0 : 5'b0_11_0_0,
                  5'b1_01_0_0, 5'b1_11_0_0, 5'b0_11_0_0};
      buttons = 4'b1010;
      for (int t = 0; t < 4; t++) begin
        tick();
        tests++;
        if (dut_vec !== exp_seq[t]) begin
          fails++;
          $display("FAIL simultaneous r=%0d t=%0d: got %b expected %b", round, t, dut_vec, exp_seq[t]);
        end
      end
      buttons = '0;
      tick();
      tick();
    end
  endtask

  task automatic test_repeat();
    int exp_off[$];
    bit exp_rep[$];
    int got_off[$];
    bit got_rep[$];
    for (int a = 0; a < 20; a++) begin
      if (a == 0 || (a >= D && (a - D) % P == 0)) begin
        exp_off.push_back(a); exp_rep.push_back(a != 0);
      end
    end
    do_reset();
    buttons = 4'b0001;
    for (int t = 0; t < 32; t++) begin
      if (t == 20) buttons = '0;
      tick();
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++; $display("FAIL repeat_model t=%0d: got %b expected %b", t, dut_vec, model_vec());
      end
      if (event_valid && event_ready) begin
        got_off.push_back(t); got_rep.push_back(event_repeat);
      end
    end
    tests++;
    if (got_off.size() != exp_off.size()) begin
      fails++;
      $display("FAIL repeat_count: got %0d expected %0d", got_off.size(), exp_off.size());
    end else begin
      tests++;
      if (got_off[0] != 1) begin
        fails++; $display("FAIL repeat_latency: got %0d expected 1", got_off[0]);
      end
      for (int k = 0; k < exp_off.size(); k++) begin
        tests++;
        if ((got_off[k] - got_off[0]) != exp_off[k] || got_rep[k] != exp_rep[k]) begin
          fails++;
          $display("FAIL repeat_event[%0d]: got offset %0d rep %0d expected offset %0d rep %0d",
                   k, got_off[k] - got_off[0], got_rep[k], exp_off[k], exp_rep[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] exp_seq [3];
    int ids[$];
    exp_seq = '{5'b1_00_0_0, 5'b1_00_0_0, 5'b1_00_0_1};
    do_reset();
    event_ready = 1'b0;
    buttons = 4'b0011;
    tick();
    for (int t = 0; t < 3; t++) begin
      if (t == 1) buttons = 4'b0001;
      if (t == 2) buttons = 4'b0011;
      tick();
      tests++;
      if (dut_vec !== exp_seq[t]) begin
        fails++; $display("FAIL backpressure_hold t=%0d: got %b expected %b", t, dut_vec, exp_seq[t]);
      end
    end
    event_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      if (event_valid && event_ready) ids.push_back(int'(event_id));
      tick();
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++; $display("FAIL backpressure_model t=%0d: got %b expected %b", t, dut_vec, model_vec());
      end
    end
    tests++;
    if (ids.size() < 2 || ids[0] != 0 || ids[1] != 1) begin
      fails++;
      $display("FAIL backpressure_order: got %0d events first %0d,%0d expected 0,1",
               ids.size(), (ids.size() > 0) ? ids[0] : -1, (ids.size() > 1) ? ids[1] : -1);
    end
    buttons = '0;
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    tests++;
    if (overflow !== 1'b0) begin
      fails++; $display("FAIL overflow_clear: got %b expected 0", overflow);
    end
  endtask

  task automatic test_async_reset();
    bit found;
    do_reset();
    buttons = 4'b0100;
    found = 0;
    for (int t = 0; t < 40 && !found; t++) begin
      tick();
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++; $display("FAIL async_model t=%0d: got %b expected %b", t, dut_vec, model_vec());
      end
      if (event_valid && event_repeat) found = 1;
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL async_reach_repeat: got no repeat event expected one within 40 cycles");
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    tests++;
    if (dut_vec !== 5'b0) begin
      fails++; $display("FAIL async_immediate: got %b expected %b", dut_vec, 5'b0);
    end
    buttons = '0;
    tick();
    tick();
    rst = 1'b1;
    for (int t = 0; t < 12; t++) begin
      tick();
      tests++;
      if (event_valid !== 1'b0) begin
        fails++; $display("FAIL async_quiet t=%0d: got valid %b expected 0", t, event_valid);
      end
    end
    buttons = 4'b0100;
    tick();
    tick();
    tests++;
    if (dut_vec !== 5'b1_10_0_0) begin
      fails++; $display("FAIL async_fresh_press: got %b expected %b", dut_vec, 5'b1_10_0_0);
    end
    buttons = '0;
    tick();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 11) == 0) buttons[i] = ~buttons[i];
      end
      event_ready  = ($urandom_range(0, 3) != 0);
      clr_overflow = ($urandom_range(0, 19) == 0);
      tick();
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++; $display("FAIL random t=%0d: got %b expected %b", t, dut_vec, model_vec());
      end
    end
    buttons = '0;
    clr_overflow = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    buttons = '0;
    event_ready = 1'b1;
    clr_overflow = 1'b0;
    model_reset();
    test_reset();
    test_single_press();
    test_simultaneous();
    test_repeat();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
